// File: rtl/cordic_result_fifo.sv
// Reader-side FWFT FIFO for CORDIC stage words: strobed capture, valid/ready drain,
// sticky overflow flag for dropped pushes.
module cordic_result_fifo #(
  parameter int WIDTH = 6,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             ovf_q;
  occ_t             occ;
  logic             pop;
  logic             push;
  logic             drop;

  // Occupancy is decoded from the count rather than held in its own register,
  // so full/empty can never disagree with the stored word count.
  always_comb begin
    occ = EMPTY;
    if (cnt_q == DEPTH_CNT) begin
      occ = FULL;
    end else if (cnt_q != '0) begin
      occ = PARTIAL;
    end
  end

  always_comb begin
    full     = (occ == FULL);
    rd_valid = (occ != EMPTY);
    pop      = rd_valid & rd_ready;
    push     = wr_en & (~full | pop);
    drop     = wr_en & full & ~pop;
    rd_data  = rd_valid ? mem[rd_ptr] : '0;
    count    = cnt_q;
    overflow = ovf_q;
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_result_fifo.sv
// Directed self-checking bench for cordic_result_fifo (WIDTH=6, DEPTH=4).
module tb_cordic_result_fifo;

  logic       CLK;
  logic       RST;
  logic       wr_en;
  logic [5:0] wr_data;
  logic       full;
  logic       rd_valid;
  logic       rd_ready;
  logic [5:0] rd_data;
  logic [2:0] count;
  logic       overflow;
  logic       clr_ovf;

  int n_checks = 0;
  int n_errors = 0;

  cordic_result_fifo #(.WIDTH(6), .AW(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [5:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  logic [5:0] q[$];
  int         n_read;

  initial begin
    RST = 1'b1; wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0; clr_ovf = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_full", full, 0);
    check("rst_data", rd_data, 0);
    step();
    RST = 1'b0;
    step();

    // FWFT latency
    push_word(6'h2A);
    check("fwft_valid", rd_valid, 1);
    check("fwft_data", rd_data, 6'h2A);
    check("fwft_count", count, 1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("fwft_pop_count", count, 0);
    check("fwft_pop_data", rd_data, 0);

    // Fill, then a dropped push
    for (int unsigned i = 1; i <= 4; i++) push_word(6'(i));
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    check("fill_ovf", overflow, 0);
    push_word(6'h05);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 4);
    rd_ready = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) begin
      check("ovf_drain", rd_data, 6'(i));
      step();
    end
    rd_ready = 1'b0;
    check("ovf_drained", rd_valid, 0);
    check("ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_clr", overflow, 0);

    // Full with simultaneous push and pop
    for (int unsigned i = 1; i <= 4; i++) push_word(6'(i));
    wr_en = 1'b1; wr_data = 6'h3F; rd_ready = 1'b1;
    check("pp_head", rd_data, 6'h01);
    step();
    wr_en = 1'b0;
    check("pp_count", count, 4);
    check("pp_full", full, 1);
    check("pp_ovf", overflow, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      logic [5:0] exp_d;
      exp_d = (i == 3) ? 6'h3F : 6'(i + 2);
      check("pp_drain", rd_data, exp_d);
      step();
    end
    rd_ready = 1'b0;
    check("pp_empty", count, 0);

    // Set wins over clear
    for (int unsigned i = 1; i <= 4; i++) push_word(6'(i));
    push_word(6'h15);
    check("ovf2_set", overflow, 1);
    clr_ovf = 1'b1;
    push_word(6'h16);
    check("ovf2_set_prio", overflow, 1);
    step();
    clr_ovf = 1'b0;
    check("ovf2_clr", overflow, 0);
    rd_ready = 1'b1;
    for (int unsigned i = 1; i <= 4; i++) begin
      check("ovf2_drain", rd_data, 6'(i));
      step();
    end
    rd_ready = 1'b0;
    check("ovf2_empty", count, 0);

    // Streaming across pointer wrap
    n_read = 0;
    rd_ready = 1'b1;
    for (int unsigned i = 0; i < 12; i++) begin
      wr_en   = (i < 10);
      wr_data = 6'(8'h20 + i);
      if (q.size() > 0) begin
        check("wrap_data", rd_data, q[0]);
        void'(q.pop_front());
        n_read++;
      end else begin
        check("wrap_idle", rd_valid, 0);
      end
      if (wr_en) q.push_back(wr_data);
      step();
      check("wrap_count", count, q.size());
    end
    wr_en = 1'b0;
    rd_ready = 1'b0;
    check("wrap_nread", n_read, 10);

    // Asynchronous reset mid-stream
    for (int unsigned i = 1; i <= 3; i++) push_word(6'(8'h30 + i));
    check("mid_count", count, 3);
    RST = 1'b1;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_data", rd_data, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_ovf", overflow, 0);
    step();
    RST = 1'b0;
    push_word(6'h0C);
    check("post_rst_data", rd_data, 6'h0C);
    check("post_rst_count", count, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
